// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// State enum, mem mode encoding, requester id.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and mem-side bundle for mem_arbiter.
// slave: arbiter side; master: requesters plus mem.
interface mem_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              r0_valid;
  logic              r0_ready;
  logic              r0_mode;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic              r1_mode;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_valid, r0_mode, r0_addr, r0_wdata,
    input  r1_valid, r1_mode, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_mode, mem_addr, mem_wdata
  );

  modport master (
    output r0_valid, r0_mode, r0_addr, r0_wdata,
    output r1_valid, r1_mode, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_mode, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker (combinational).
// valid[1:0], last_gnt in; one-hot gnt and winner id out.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_gnt,
  output logic [1:0] gnt,
  output req_id_t    id
);

  always_comb begin
    gnt = '0;
    id  = REQ0;
    unique case (1'b1)
      (valid[0] & valid[1]):
        id = (last_gnt == REQ1) ? REQ0 : REQ1;
      (valid[0] & ~valid[1]):
        id = REQ0;
      (~valid[0] & valid[1]):
        id = REQ1;
      default: ;
    endcase
    gnt[id] = |valid;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer in front of single-port mem.
// Ports: clk, rst_n, bus (mem_arb_if.slave).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  state_t            state;
  req_id_t           last_gnt;
  req_id_t           gnt_id;
  req_id_t           win_id;
  logic [1:0]        gnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic [1:0]        rvalid_q;
  logic              idle;
  logic              hs;
  logic              sel_mode;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr (
    .valid    ({bus.r1_valid, bus.r0_valid}),
    .last_gnt (last_gnt),
    .gnt      (gnt),
    .id       (win_id)
  );

  // rst_n gates ready so nothing is granted while reset is held.
  assign idle = rst_n & (state == IDLE);

  assign bus.r0_ready = idle & gnt[0];
  assign bus.r1_ready = idle & gnt[1];

  assign hs = (bus.r0_valid & bus.r0_ready)
            | (bus.r1_valid & bus.r1_ready);

  assign sel_mode  = win_id ? bus.r1_mode  : bus.r0_mode;
  assign sel_addr  = win_id ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = win_id ? bus.r1_wdata : bus.r0_wdata;

  // The latched fields are the mem drive; they rest at
  // read/0/0 whenever the FSM is outside ACCESS.
  assign bus.mem_mode  = mode_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.r0_rvalid = rvalid_q[0];
  assign bus.r1_rvalid = rvalid_q[1];
  assign bus.r0_rdata  = resp_q;
  assign bus.r1_rdata  = resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= REQ1;
      gnt_id   <= REQ0;
      lat_cnt  <= '0;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
      rvalid_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs) begin
            mode_q   <= sel_mode;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            gnt_id   <= win_id;
            last_gnt <= win_id;
            lat_cnt  <= LAT_W'(MEM_LAT);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            resp_q <= (mode_q == MODE_READ) ?
                      bus.mem_rdata : '0;
            rvalid_q[gnt_id] <= 1'b1;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            state   <= RESP;
          end
        end
        RESP: begin
          rvalid_q <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=3).
// Simple memory models answer on the mem side.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mem_arb_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_arb_if #(.ADDR_W(64), .DATA_W(64)) b3 ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) d1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) d3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  logic [63:0] mem1 [32];
  logic [63:0] mem3 [32];

  assign b1.mem_rdata = mem1[b1.mem_addr[4:0]];
  assign b3.mem_rdata = mem3[b3.mem_addr[4:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= '0;
        mem3[i] <= (i == 8) ? 64'h1234 : 64'h0;
      end
    end else begin
      if (b1.mem_mode == 1'b0) mem1[b1.mem_addr[4:0]] <= b1.mem_wdata;
      if (b3.mem_mode == 1'b0) mem3[b3.mem_addr[4:0]] <= b3.mem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? b1.r1_ready : b1.r0_ready;
  endfunction

  function automatic logic rv(input bit id);
    return id ? b1.r1_rvalid : b1.r0_rvalid;
  endfunction

  function automatic logic [63:0] rd(input bit id);
    return id ? b1.r1_rdata : b1.r0_rdata;
  endfunction

  task automatic drive(input bit id, input logic v, input logic md,
                       input logic [63:0] a, input logic [63:0] wd);
    if (id) begin
      b1.r1_valid = v; b1.r1_mode = md;
      b1.r1_addr  = a; b1.r1_wdata = wd;
    end else begin
      b1.r0_valid = v; b1.r0_mode = md;
      b1.r0_addr  = a; b1.r0_wdata = wd;
    end
  endtask

  // Single request on d1; checks mem drive and rvalid at grant+2.
  task automatic xact(input bit id, input logic md,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] exp, input string tag);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, md, a, wd);
    @(negedge clk);
    while (!rdy(id) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt"}, 64'(rdy(id)), 64'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, md, a, wd);
    @(negedge clk);
    chk({tag, "_mode"}, 64'(b1.mem_mode), 64'(md));
    chk({tag, "_addr"}, b1.mem_addr, a);
    chk({tag, "_early_rv"}, 64'(rv(id)), 64'd0);
    @(negedge clk);
    chk({tag, "_rvalid"}, 64'(rv(id)), 64'd1);
    chk({tag, "_other_rv"}, 64'(rv(!id)), 64'd0);
    chk({tag, "_rdata"}, rd(id), exp);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 64'd0, 64'd0);
    b3.r0_valid = 1'b0; b3.r0_mode = 1'b1;
    b3.r0_addr = '0; b3.r0_wdata = '0;
    b3.r1_valid = 1'b0; b3.r1_mode = 1'b1;
    b3.r1_addr = '0; b3.r1_wdata = '0;

    // Reset values, ready held low while in reset
    repeat (2) @(posedge clk);
    #1 b1.r0_valid = 1'b1;
    #1;
    chk("rst_r0_ready", 64'(b1.r0_ready), 64'd0);
    chk("rst_r1_ready", 64'(b1.r1_ready), 64'd0);
    chk("rst_rvalid", 64'({b1.r1_rvalid, b1.r0_rvalid}), 64'd0);
    chk("rst_rdata", b1.r0_rdata | b1.r1_rdata, 64'd0);
    chk("rst_mem_mode", 64'(b1.mem_mode), 64'd1);
    chk("rst_mem_addr", b1.mem_addr, 64'd0);
    chk("rst_mem_wdata", b1.mem_wdata, 64'd0);
    b1.r0_valid = 1'b0;
    rst_n = 1'b1;

    // Tie after reset: r0, r1, r0, r1
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 64'd0, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'd8, 64'd0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge clk);
      while (!(b1.r0_ready | b1.r1_ready) && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("tie_r0_ready", 64'(b1.r0_ready), 64'(k % 2 == 0));
      chk("tie_r1_ready", 64'(b1.r1_ready), 64'(k % 2 == 1));
      @(posedge clk);
    end
    #1;
    b1.r0_valid = 1'b0;
    b1.r1_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Write then read
    xact(1'b0, 1'b0, 64'd0, 64'd2017, 64'd0, "wr0");
    @(negedge clk);
    chk("wr0_single_pulse", 64'(b1.r0_rvalid), 64'd0);
    xact(1'b1, 1'b1, 64'd0, 64'd0, 64'd2017, "rd1");

    // Starvation: r1 arrives during r0's ACCESS
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 64'd8, 64'd0);
    @(negedge clk);
    chk("stv_r0_gnt", 64'(b1.r0_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 64'd0, 64'd0);
    @(negedge clk);
    chk("stv_access_rdy", 64'({b1.r1_ready, b1.r0_ready}), 64'd0);
    @(negedge clk);
    chk("stv_r0_rvalid", 64'(b1.r0_rvalid), 64'd1);
    chk("stv_r0_rdata", b1.r0_rdata, 64'd0);
    @(negedge clk);
    chk("stv_r1_first", 64'({b1.r1_ready, b1.r0_ready}), 64'b10);
    @(posedge clk); #1;
    b1.r1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stv_r1_rdata", b1.r1_rdata, 64'd2017);
    @(negedge clk);
    chk("stv_r0_again", 64'(b1.r0_ready), 64'd1);
    @(posedge clk); #1;
    b1.r0_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Idle safety with toggling write data
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      b1.r0_mode  = 1'b0;
      b1.r0_addr  = 64'd5;
      b1.r0_wdata = (k % 2 == 1) ? '1 : 64'h0;
      @(negedge clk);
      chk("idle_mem_mode", 64'(b1.mem_mode), 64'd1);
      chk("idle_mem_addr", b1.mem_addr, 64'd0);
    end
    xact(1'b0, 1'b1, 64'd0, 64'd0, 64'd2017, "rdback");

    // Reset during a write
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 64'd16, 64'hDEAD);
    @(negedge clk);
    chk("rw_gnt", 64'(b1.r0_ready), 64'd1);
    @(posedge clk); #1;
    b1.r0_valid = 1'b0;
    #1;
    chk("rw_mode_wr", 64'(b1.mem_mode), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_mode_async", 64'(b1.mem_mode), 64'd1);
    chk("rw_addr_async", b1.mem_addr, 64'd0);
    chk("rw_wdata_async", b1.mem_wdata, 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rw_no_rvalid", 64'({b1.r1_rvalid, b1.r0_rvalid}), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 64'd0, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 64'd8, 64'd0);
    @(negedge clk);
    chk("rw_tie_after", 64'({b1.r1_ready, b1.r0_ready}), 64'b01);
    chk("rw_no_rvalid2", 64'({b1.r1_rvalid, b1.r0_rvalid}), 64'd0);
    @(posedge clk); #1;
    b1.r0_valid = 1'b0;
    b1.r1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // MEM_LAT=3 timing on d3
    @(posedge clk); #1;
    b3.r0_valid = 1'b1;
    b3.r0_mode  = 1'b1;
    b3.r0_addr  = 64'd8;
    @(negedge clk);
    chk("l3_gnt", 64'(b3.r0_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("l3_mem_addr", b3.mem_addr, 64'd8);
      chk("l3_mem_mode", 64'(b3.mem_mode), 64'd1);
      chk("l3_early_rv", 64'(b3.r0_rvalid), 64'd0);
      chk("l3_no_regrant", 64'(b3.r0_ready), 64'd0);
    end
    @(negedge clk);
    chk("l3_rvalid", 64'(b3.r0_rvalid), 64'd1);
    chk("l3_rdata", b3.r0_rdata, 64'h1234);
    chk("l3_resp_addr", b3.mem_addr, 64'd0);
    chk("l3_resp_rdy", 64'(b3.r0_ready), 64'd0);
    @(negedge clk);
    chk("l3_next_gnt", 64'(b3.r0_ready), 64'd1);
    chk("l3_rv_drop", 64'(b3.r0_rvalid), 64'd0);
    @(posedge clk); #1;
    b3.r0_valid = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `mem` block. Two requesters (e.g. fetch and load/store) issue read or write transactions through valid/ready handshakes. The arbiter grants one requester at a time in round-robin order and drives `mem` mode/address/dataIn only for the duration of a granted access. It returns read data through a registered one-cycle response pulse.

## Interface
- `ADDR_W`, 64, address width; matches `mem` address.
- `DATA_W`, 64, data width; matches `mem` dataIn/dataOut.
- `MEM_LAT`, 1, cycles `mem` outputs are held before dataOut is sampled; legal range ≥1.

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `r0_valid` / `r1_valid`  in  1  request present; held until ready
- `r0_ready` / `r1_ready`  out  1  grant; the transfer occurs when valid&ready
- `r0_mode` / `r1_mode`  in  1  0 = write, 1 = read (`mem` encoding)
- `r0_addr` / `r1_addr`  in  ADDR_W  request address
- `r0_wdata` / `r1_wdata`  in  DATA_W  write data
- `r0_rvalid` / `r1_rvalid`  out  1  one-cycle completion pulse, for both reads and writes
- `r0_rdata` / `r1_rdata`  out  DATA_W  read data, valid with rvalid; 0 for writes
- `mem_mode`  out  1  to `mem` mode
- `mem_addr`  out  ADDR_W  to `mem` address
- `mem_wdata`  out  DATA_W  to `mem` dataIn
- `mem_rdata`  in  DATA_W  from `mem` dataOut

## Operation
FSM states: IDLE, ACCESS, RESP.

- **IDLE**
  - If neither valid is high, stay in IDLE.
  - Otherwise select a winner. If only one requester is valid, it wins. If both are valid, the requester not granted last wins (`last_gnt` pointer).
  - Assert the winner's ready combinationally in the same cycle. Never assert both readies.
  - On the handshake: latch mode, addr, wdata and the winner id; update `last_gnt`; load `lat_cnt`=MEM_LAT; go to ACCESS.
- **ACCESS**
  - Drive `mem_mode`/`mem_addr`/`mem_wdata` from the latched registers.
  - Decrement `lat_cnt` each cycle.
  - In the cycle `lat_cnt`==1:
    - Capture `mem_rdata` into the response register for reads; capture 0 for writes.
    - Go to RESP.
- **RESP**
  - Pulse rvalid of the latched winner only. Its rdata holds the captured value.
  - Go to IDLE.
- **Outside ACCESS**
  - Hold `mem_mode`=1 (read), `mem_addr`=0 and `mem_wdata`=0, so `mem` never sees a spurious write.
- **Data handling**
  - No address alignment checks and no width conversion; fields pass through at full width.
  - `lat_cnt` width is $clog2(MEM_LAT+1).
- **Requester obligations**
  - Requesters must hold valid and fields stable until ready. The arbiter does not check this.
  - A requester may keep valid high during its own ACCESS/RESP. It is re-arbitrated in IDLE.

## Timing
- Handshake in cycle T. `mem` is driven in cycles T+1 .. T+MEM_LAT. rvalid is high in cycle T+MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles. No pipelining.
- Fairness: with both requesters continuously valid, grants alternate r0, r1, r0, …
- A requester waits at most one foreign transaction.
- Reset values:
  - state=IDLE and `last_gnt`=r1, so r0 wins the first tie.
  - `lat_cnt`=0.
  - All ready/rvalid=0 and all rdata=0.
  - `mem_mode`=1, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-transaction:
  - Asserting `rst_n` low in any state returns all outputs to their reset values immediately (asynchronously).
  - An in-flight write is abandoned: `mem_mode` goes to 1 at once.
  - No rvalid is issued for the aborted transaction.
- Deassertion of `rst_n` takes effect at the next rising clock edge.

## Structure
- `mem_arb_pkg`:
  - state enum (IDLE/ACCESS/RESP);
  - `MODE_WRITE`=1'b0 and `MODE_READ`=1'b1;
  - requester id type (1 bit).
- Sub-module `rr_arb2`: combinational two-way round-robin picker.
  - Inputs: two valids and `last_gnt`.
  - Outputs: a one-hot grant and the winner id.
  - Instantiated once.
- FSM, latches and response registers live in `mem_arbiter`.

## Test plan
- **Write then read:** r0 writes addr 0, data 2017 at T. r1 then reads addr 0. r1_rvalid pulses at its grant+MEM_LAT+1 with r1_rdata=2017. r0_rvalid pulses once with rdata=0.
- **Tie after reset:** r0 and r1 both valid in the first cycle. r0 is granted first, then r1, then r0. Grants strictly alternate while both stay valid.
- **Starvation check:** r0 issues back-to-back reads to addr 8. r1 raises valid mid-ACCESS. r1 is granted in the next IDLE, before r0's second transaction.
- **Reset during write:** `rst_n` asserted low in ACCESS of a write to addr 16 with data 0xDEAD. `mem_mode` returns to 1 in the same cycle and no rvalid is issued. After release, a tie grants r0.
- **Idle safety:** no valids, r0_wdata toggling. `mem_mode` stays 1 and `mem_addr` stays 0. A subsequent read of addr 0 returns the previously written 2017.
- **MEM_LAT=3 instance:** a read handshake at cycle T gives rvalid exactly at T+4. `mem` is driven for cycles T+1..T+3. The next grant occurs no earlier than T+5.
